// File: rtl/pong_pkg.sv
// Shared constants for the pong game sequencer: state encoding, default
// timing/score parameters and serve direction values.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_SERVE_TICKS = 60;
  localparam int DEF_POINT_TICKS = 90;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/tick_timer.sv
// Loadable frame-tick counter; done_o flags the tick that reaches last_i,
// at which point the count wraps back to zero.
module tick_timer #(
  parameter int TW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [TW-1:0] last_i,
  output logic          done_o
);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == last_i);
  assign done_o  = en_i & at_last & ~clr_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: gates paddle/ball enables, commands serves, keeps
// scores and detects the end of the game.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int POINT_TICKS = DEF_POINT_TICKS,
  parameter int SW          = 4,
  parameter int TW          = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          start,
  input  logic          miss_left,
  input  logic          miss_right,
  output logic          paddle_en,
  output logic          ball_en,
  output logic          ball_serve,
  output logic          serve_dir,
  output logic [SW-1:0] score_left,
  output logic [SW-1:0] score_right,
  output logic          game_over,
  output logic          winner
);

  localparam logic [SW-1:0] WIN_S      = SW'(WIN_SCORE);
  localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_TICKS - 1);
  localparam logic [TW-1:0] POINT_LAST = TW'(POINT_TICKS - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] score_l_q, score_l_d;
  logic [SW-1:0] score_r_q, score_r_d;
  logic          dir_q, dir_d;
  logic          winner_q, winner_d;
  logic          start_q;
  logic          start_rise;
  logic          timed_state;
  logic          tmr_done;
  logic [TW-1:0] tmr_last;

  assign start_rise  = start & ~start_q;
  assign timed_state = (state_q == ST_SERVE) || (state_q == ST_POINT);
  assign tmr_last    = (state_q == ST_SERVE) ? SERVE_LAST : POINT_LAST;

  // Held at zero outside SERVE/POINT so every timed phase starts fresh.
  tick_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (~timed_state),
    .en_i   (tick & timed_state),
    .last_i (tmr_last),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    dir_d     = dir_q;
    winner_d  = winner_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (tmr_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (miss_left && miss_right) begin
          state_d = ST_SERVE;
        end else if (miss_left) begin
          if (score_r_q < WIN_S) score_r_d = score_r_q + SW'(1);
          dir_d   = DIR_LEFT;
          state_d = ST_POINT;
        end else if (miss_right) begin
          if (score_l_q < WIN_S) score_l_d = score_l_q + SW'(1);
          dir_d   = DIR_RIGHT;
          state_d = ST_POINT;
        end
      end
      ST_POINT: begin
        if (tmr_done) begin
          if ((score_l_q == WIN_S) || (score_r_q == WIN_S)) begin
            state_d  = ST_OVER;
            winner_d = (score_r_q == WIN_S);
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          score_l_d = '0;
          score_r_d = '0;
          dir_d     = DIR_LEFT;
          state_d   = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
      dir_q     <= DIR_LEFT;
      winner_q  <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      dir_q     <= dir_d;
      winner_q  <= winner_d;
      start_q   <= start;
    end
  end

  assign paddle_en   = tick & ((state_q == ST_SERVE) || (state_q == ST_PLAY));
  assign ball_en     = tick & (state_q == ST_PLAY);
  assign ball_serve  = (state_q == ST_SERVE);
  assign game_over   = (state_q == ST_OVER);
  assign serve_dir   = dir_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios plus randomized
// stimulus against a phase/ticks-remaining reference model.
module tb_pong_game_ctrl;

  localparam int WIN = 3;
  localparam int SERVE_T = 2;
  localparam int POINT_T = 3;

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic miss_left = 1'b0;
  logic miss_right = 1'b0;
  logic paddle_en, ball_en, ball_serve, serve_dir, game_over, winner;
  logic [3:0] score_left, score_right;

  int checks = 0;
  int failures = 0;
  int tphase = 0;
  bit rand_tick = 0;

  // Reference model state
  int m_phase = M_IDLE;
  int m_left_ticks = 0;
  int m_sl = 0, m_sr = 0;
  bit m_dir = 0, m_win = 0, m_prev_start = 0;

  pong_game_ctrl #(
    .WIN_SCORE(WIN), .SERVE_TICKS(SERVE_T), .POINT_TICKS(POINT_T), .SW(4), .TW(7)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
    .paddle_en(paddle_en), .ball_en(ball_en), .ball_serve(ball_serve),
    .serve_dir(serve_dir), .score_left(score_left), .score_right(score_right),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic void model_update();
    bit rise;
    if (reset) begin
      m_phase = M_IDLE; m_left_ticks = 0; m_sl = 0; m_sr = 0;
      m_dir = 0; m_win = 0; m_prev_start = 0;
      return;
    end
    rise = start && !m_prev_start;
    m_prev_start = start;
    case (m_phase)
      M_IDLE: if (rise) begin m_phase = M_SERVE; m_left_ticks = SERVE_T; end
      M_SERVE: if (tick) begin
        m_left_ticks--;
        if (m_left_ticks == 0) m_phase = M_PLAY;
      end
      M_PLAY: begin
        if (miss_left && miss_right) begin
          m_phase = M_SERVE; m_left_ticks = SERVE_T;
        end else if (miss_left || miss_right) begin
          if (miss_left) m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1;
          else           m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1;
          m_dir = miss_right;
          m_phase = M_POINT; m_left_ticks = POINT_T;
        end
      end
      M_POINT: if (tick) begin
        m_left_ticks--;
        if (m_left_ticks == 0) begin
          if (m_sl == WIN || m_sr == WIN) begin
            m_phase = M_OVER; m_win = (m_sr == WIN);
          end else begin
            m_phase = M_SERVE; m_left_ticks = SERVE_T;
          end
        end
      end
      default: if (rise) begin
        m_sl = 0; m_sr = 0; m_dir = 0;
        m_phase = M_SERVE; m_left_ticks = SERVE_T;
      end
    endcase
  endfunction

  // winner is only meaningful while game_over is high, so it is masked.
  function automatic logic [13:0] model_out();
    bit live = (m_phase == M_SERVE) || (m_phase == M_PLAY);
    return {tick && live, tick && (m_phase == M_PLAY), m_phase == M_SERVE, m_dir,
            4'(m_sl), 4'(m_sr), m_phase == M_OVER, (m_phase == M_OVER) && m_win};
  endfunction

  function automatic logic [13:0] dut_out();
    return {paddle_en, ball_en, ball_serve, serve_dir, score_left, score_right,
            game_over, game_over & winner};
  endfunction

  task automatic step(input logic st, input logic ml, input logic mr);
    start = st; miss_left = ml; miss_right = mr;
    tick = rand_tick ? ($urandom_range(0, 2) == 0) : (tphase % 4 == 3);
    tphase++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_until(input int target, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (m_phase == target) begin ok = 1; return; end
      step(0, 0, 0);
    end
    ok = (m_phase == target);
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      checks++;
      if (dut_out() !== 14'd0) begin
        failures++; $display("FAIL reset_hold got=%h exp=%h", dut_out(), 14'd0);
      end
    end
    step(0, 0, 0);
    reset = 0;
    step(0, 0, 0);
    checks++;
    if (dut_out() !== 14'd0) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", dut_out(), 14'd0);
    end
    step(1, 0, 0);
    checks++;
    if (ball_serve !== 1'b1 || dut_out() !== model_out()) begin
      failures++; $display("FAIL start_to_serve got=%h exp=%h", dut_out(), model_out());
    end
    $display("test_reset done: serve=%0b", ball_serve);
  endtask

  task automatic test_serve();
    int nticks = 0;
    for (int i = 0; i < 20 && m_phase == M_SERVE; i++) begin
      step(0, 0, 0);
      if (tick) nticks++;
    end
    checks++;
    if (m_phase != M_PLAY || nticks != SERVE_T || dut_out() !== model_out()) begin
      failures++;
      $display("FAIL serve_ticks got=%0d out=%h exp=%0d out=%h", nticks, dut_out(), SERVE_T, model_out());
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      checks++;
      if (ball_en !== tick || paddle_en !== tick || ball_serve !== 1'b0) begin
        failures++;
        $display("FAIL play_enables got=%b%b%b exp=%b%b0", ball_en, paddle_en, ball_serve, tick, tick);
      end
    end
    $display("test_serve done: ticks=%0d", nticks);
  endtask

  task automatic test_point_left();
    int nticks = 0;
    bit ok;
    step(0, 1, 0);
    checks++;
    if (score_right !== 4'd1 || serve_dir !== 1'b0 || ball_serve !== 1'b0 || score_left !== 4'd0) begin
      failures++;
      $display("FAIL point_left got=%0d/%0d dir=%b exp=0/1 dir=0", score_left, score_right, serve_dir);
    end
    for (int i = 0; i < 30 && m_phase == M_POINT; i++) begin
      step(0, 0, 0);
      if (tick) nticks++;
      checks++;
      if (m_phase == M_POINT && (paddle_en !== 1'b0 || ball_en !== 1'b0)) begin
        failures++; $display("FAIL point_freeze got=%b%b exp=00", paddle_en, ball_en);
      end
    end
    checks++;
    if (nticks != POINT_T || ball_serve !== 1'b1) begin
      failures++; $display("FAIL point_hold got=%0d serve=%b exp=%0d serve=1", nticks, ball_serve, POINT_T);
    end
    run_until(M_PLAY, 30, ok);
    checks++;
    if (!ok || dut_out() !== model_out()) begin
      failures++; $display("FAIL reach_play got=%h exp=%h", dut_out(), model_out());
    end
    $display("test_point_left done: score=%0d-%0d", score_left, score_right);
  endtask

  task automatic test_double_miss();
    bit ok;
    step(0, 1, 1);
    checks++;
    if (score_left !== 4'd0 || score_right !== 4'd1 || ball_serve !== 1'b1 || serve_dir !== 1'b0) begin
      failures++;
      $display("FAIL double_miss got=%0d/%0d serve=%b exp=0/1 serve=1", score_left, score_right, ball_serve);
    end
    run_until(M_PLAY, 30, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL replay_to_play got=%0d exp=%0d", m_phase, M_PLAY); end
    $display("test_double_miss done");
  endtask

  task automatic test_win();
    bit ok;
    for (int k = 1; k <= WIN; k++) begin
      step(0, 0, 1);
      checks++;
      if (score_left !== 4'(k) || serve_dir !== 1'b1) begin
        failures++; $display("FAIL win_point%0d got=%0d exp=%0d", k, score_left, k);
      end
      run_until((k < WIN) ? M_PLAY : M_OVER, 40, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL win_progress%0d got=%0d", k, m_phase); end
    end
    checks++;
    if (game_over !== 1'b1 || winner !== 1'b0 || ball_serve !== 1'b0) begin
      failures++; $display("FAIL game_over got=%b win=%b exp=1 win=0", game_over, winner);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, i[0], 1);
      checks++;
      if (score_left !== 4'd3 || score_right !== 4'd1 || game_over !== 1'b1) begin
        failures++; $display("FAIL over_hold got=%0d/%0d exp=3/1", score_left, score_right);
      end
    end
    step(1, 0, 0);
    checks++;
    if (score_left !== 4'd0 || score_right !== 4'd0 || ball_serve !== 1'b1 || game_over !== 1'b0) begin
      failures++; $display("FAIL restart got=%0d/%0d serve=%b exp=0/0 serve=1", score_left, score_right, ball_serve);
    end
    step(0, 0, 0);
    $display("test_win done");
  endtask

  task automatic test_reset_midgame();
    bit ok;
    run_until(M_PLAY, 30, ok);
    reset = 1;
    step(0, 0, 0);
    checks++;
    if (dut_out() !== 14'd0) begin
      failures++; $display("FAIL reset_in_play got=%h exp=%h", dut_out(), 14'd0);
    end
    reset = 0;
    step(1, 0, 0);
    run_until(M_PLAY, 30, ok);
    step(0, 0, 1);
    checks++;
    if (!ok || score_left !== 4'd1) begin
      failures++; $display("FAIL pre_reset_point got=%0d exp=1", score_left);
    end
    reset = 1;
    step(0, 0, 0);
    checks++;
    if (dut_out() !== 14'd0) begin
      failures++; $display("FAIL reset_in_point got=%h exp=%h", dut_out(), 14'd0);
    end
    reset = 0;
    $display("test_reset_midgame done");
  endtask

  task automatic test_random();
    logic st = 0;
    int bad = 0;
    rand_tick = 1;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) st = ~st;
      step(st, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++; bad++;
        if (bad <= 10) $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_out(), model_out());
      end
    end
    reset = 0;
    rand_tick = 0;
    $display("test_random done: mismatches=%0d", bad);
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point_left();
    test_double_miss();
    test_win();
    test_reset_midgame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level game sequencer for the pong datapath.
- Decides when the paddle counters and the ball mover may advance, and commands serves.
- Keeps both players' scores and detects the end of the game.
- Sits between the frame-rate tick from the clock divider, the debounced start button, and the paddle/ball blocks; its outputs gate their count enables.

Parameters:
- WIN_SCORE, 7, points needed to win; scores saturate here.
- SERVE_TICKS, 60, frame ticks held in SERVE before the ball is released.
- POINT_TICKS, 90, frame ticks of freeze after a point.
- SW, 4, score width in bits; must satisfy WIN_SCORE < 2^SW.
- TW, 7, tick-counter width; must hold max(SERVE_TICKS, POINT_TICKS).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled on posedge clk only
- tick  in  1  one-clk pulse per frame (from clock divider domain, already synchronous to clk)
- start  in  1  debounced start button, level
- miss_left  in  1  ball passed left paddle (from ball logic), level
- miss_right  in  1  ball passed right paddle, level
- paddle_en  out  1  paddle counters may step this cycle
- ball_en  out  1  ball mover may step this cycle
- ball_serve  out  1  ball logic reloads centre position and direction
- serve_dir  out  1  0 = serve toward left player, 1 = toward right
- score_left  out  SW  left player score
- score_right  out  SW  right player score
- game_over  out  1  high while in OVER
- winner  out  1  0 = left won, 1 = right won; valid only while game_over = 1

Behaviour:
- Registered state: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4 (3-bit encoding).
- Also registered: tick counter tcnt[TW-1:0], both scores, serve_dir, winner, start_q (previous start).
- Reset (synchronous) values:
  - state = IDLE, tcnt = 0, scores = 0, serve_dir = 0, winner = 0, start_q = 0.
  - All outputs 0, except ball_serve, which is 0 because the state is IDLE.
  - Reset has priority over every other input and may be applied in any state.
- start_rise = start & ~start_q; start_q updates every cycle.
- Output decode, combinational from registered state and current tick:
  - paddle_en = tick & (state == SERVE | state == PLAY).
  - ball_en = tick & (state == PLAY).
  - ball_serve = (state == SERVE).
  - game_over = (state == OVER).
- IDLE: on start_rise, go to SERVE with tcnt = 0. Scores are not touched.
- SERVE: on each tick, tcnt++. When tick arrives with tcnt == SERVE_TICKS-1, go to PLAY with tcnt = 0. Miss inputs are ignored.
- PLAY:
  - miss_left alone: score_right++, serve_dir = 0, go to POINT.
  - miss_right alone: score_left++, serve_dir = 1, go to POINT.
  - Both in the same cycle: no score change, serve_dir unchanged, go to SERVE (replay).
  - Misses are acted on in the cycle they are sampled and do not require tick.
- POINT: on each tick, tcnt++. At tick with tcnt == POINT_TICKS-1, tcnt = 0, then:
  - if either score == WIN_SCORE, go to OVER; winner = (score_right == WIN_SCORE);
  - otherwise go to SERVE.
- OVER: hold. On start_rise, clear both scores, set serve_dir = 0, go to SERVE.
- Scores saturate at WIN_SCORE and never wrap. Only one score can change per point.
- A start level held across reset must not start a game: start_q resets to 0, so a held start produces exactly one rise after reset.
- Latency:
  - State changes take effect on the clock edge after the qualifying input.
  - Enables follow tick in the same cycle once in the qualifying state.

Decomposition:
- Shared package pong_pkg holds:
  - state encoding constants (ST_IDLE..ST_OVER);
  - default WIN_SCORE, SERVE_TICKS, POINT_TICKS;
  - direction constants DIR_LEFT = 0, DIR_RIGHT = 1.
- One natural sub-module: tick_timer (loadable tick counter with terminal-count flag), shared by SERVE and POINT.
- Scores and FSM stay in the top module.

Test Plan:
(bench parameters: WIN_SCORE = 3, SERVE_TICKS = 2, POINT_TICKS = 3; tick every 4 clks)
- Reset applied with start held high -> state = IDLE, all outputs 0. Release then re-press start -> SERVE one clk later, ball_serve = 1.
- In SERVE, two ticks -> PLAY after the second tick. ball_en pulses coincide with tick; ball_serve = 0.
- PLAY with miss_left pulse -> score_right = 1, serve_dir = 0, POINT. Three ticks with paddle_en = 0 -> SERVE.
- PLAY with miss_left and miss_right in the same clk -> scores unchanged, state = SERVE.
- Three miss_right points -> score_left = 3. After the POINT hold, game_over = 1, winner = 0. Extra misses keep score_left = 3. start_rise -> scores 0, SERVE.
- Reset asserted in PLAY and in POINT -> next clk: state = IDLE, scores 0, all enables 0.
